dm_bus_arbiter: RTL

// Shares the debug module's single system-bus master port (req/gnt/r_valid protocol) between

---
 rtl/dm_bus_arbiter_pkg.sv | 11 +
 rtl/dm_bus_arbiter_rr_pick.sv | 33 +++
 rtl/dm_bus_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dm_bus_arbiter_pkg.sv
// Shared types for the debug-module system-bus arbiter.
package dm_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ArbIdle,
      ArbReq,
      ArbResp,
      ArbDrain
   } arb_state_e;

endpackage

// File: rtl/dm_bus_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after the pointer, wrapping mod N.
module dm_rr_pick #(
   parameter int unsigned N  = 2,
   parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          valid_o
);

   int unsigned   c;
   logic [IW-1:0] cidx;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      c       = 0;
      cidx    = '0;
      for (int unsigned i = 0; i < N; i++) begin
         c    = (32'(ptr_i) + i) % N;
         cidx = IW'(c);
         if (!valid_o && req_i[cidx]) begin
            valid_o     = 1'b1;
            idx_o       = cidx;
            gnt_o[cidx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dm_bus_arbiter.sv
// Shares one system-bus master port between NrReq requesters, one transaction in flight,
// with response routing back to the issuer and a response timeout.
module dm_bus_arbiter
   import dm_bus_arbiter_pkg::*;
#(
   parameter int unsigned NrReq         = 2,
   parameter int unsigned BusWidth      = 32,
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NrReq-1:0]                    req_i,
   input  logic [NrReq-1:0][BusWidth-1:0]      add_i,
   input  logic [NrReq-1:0]                    we_i,
   input  logic [NrReq-1:0][BusWidth-1:0]      wdata_i,
   input  logic [NrReq-1:0][BusWidth/8-1:0]    be_i,
   output logic [NrReq-1:0]                    gnt_o,
   output logic [NrReq-1:0]                    r_valid_o,
   output logic                                r_err_o,
   output logic                                r_other_err_o,
   output logic [BusWidth-1:0]                 r_rdata_o,
   output logic                                master_req_o,
   output logic [BusWidth-1:0]                 master_add_o,
   output logic                                master_we_o,
   output logic [BusWidth-1:0]                 master_wdata_o,
   output logic [BusWidth/8-1:0]               master_be_o,
   input  logic                                master_gnt_i,
   input  logic                                master_r_valid_i,
   input  logic                                master_r_err_i,
   input  logic                                master_r_other_err_i,
   input  logic [BusWidth-1:0]                 master_r_rdata_i,
   output logic                                busy_o,
   output logic                                timeout_o
);

   localparam int unsigned IW   = (NrReq > 1) ? $clog2(NrReq) : 1;
   localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
   localparam logic [CntW-1:0] TmoLast = (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;

   arb_state_e      state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d, ptr_q, ptr_d, sel, ptr_nxt;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [NrReq-1:0] pick_gnt;
   logic [IW-1:0]   pick_idx;
   logic            pick_valid, drive;

   dm_rr_pick #(.N(NrReq), .IW(IW)) i_pick (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .gnt_o   (pick_gnt),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   assign ptr_nxt = (idx_q == IW'(NrReq - 1)) ? '0 : idx_q + 1'b1;

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      ptr_d         = ptr_q;
      cnt_d         = '0;
      sel           = idx_q;
      drive         = 1'b0;
      gnt_o         = '0;
      r_valid_o     = '0;
      r_err_o       = 1'b0;
      r_other_err_o = 1'b0;
      r_rdata_o     = '0;
      timeout_o     = 1'b0;
      unique case (state_q)
         ArbIdle: begin
            if (pick_valid) begin
               drive = 1'b1;
               sel   = pick_idx;
               idx_d = pick_idx;
               if (master_gnt_i) begin
                  gnt_o   = pick_gnt;
                  state_d = ArbResp;
               end else begin
                  state_d = ArbReq;
               end
            end
         end
         ArbReq: begin
            drive = 1'b1;
            if (master_gnt_i) begin
               gnt_o[idx_q] = 1'b1;
               state_d      = ArbResp;
            end
         end
         ArbResp: begin
            cnt_d = cnt_q + 1'b1;
            if (master_r_valid_i) begin
               r_valid_o[idx_q] = 1'b1;
               r_rdata_o        = master_r_rdata_i;
               r_other_err_o    = master_r_other_err_i;
               r_err_o          = master_r_err_i & ~master_r_other_err_i;
               ptr_d            = ptr_nxt;
               cnt_d            = '0;
               state_d          = ArbIdle;
            end else if ((TimeoutCycles != 0) && (cnt_q == TmoLast)) begin
               r_valid_o[idx_q] = 1'b1;
               r_other_err_o    = 1'b1;
               timeout_o        = 1'b1;
               ptr_d            = ptr_nxt;
               cnt_d            = '0;
               state_d          = ArbDrain;
            end
         end
         ArbDrain: begin
            // The hung transaction's late response is swallowed here.
            if (master_r_valid_i) state_d = ArbIdle;
         end
         default: state_d = ArbIdle;
      endcase
      // Inputs may be live during reset; keep every output quiet until release.
      if (!rst_ni) begin
         drive         = 1'b0;
         gnt_o         = '0;
         r_valid_o     = '0;
         r_err_o       = 1'b0;
         r_other_err_o = 1'b0;
         r_rdata_o     = '0;
         timeout_o     = 1'b0;
      end
   end

   assign master_req_o   = drive;
   assign master_add_o   = drive ? add_i[sel]   : '0;
   assign master_we_o    = drive ? we_i[sel]    : 1'b0;
   assign master_wdata_o = drive ? wdata_i[sel] : '0;
   assign master_be_o    = drive ? be_i[sel]    : '0;
   assign busy_o         = (state_q != ArbIdle);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ArbIdle;
         idx_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
